// File: rtl/i2s_pkg.sv
// ----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmit controller: controller state
// encoding, slot/frame counter constants, sample width and the fetch-window
// helper used by i2s_ctrl.
// ----------------------------------------------------------------------------
package i2s_pkg;

   localparam int DATA_W = 16;

   // cnt_lrc[3:0] value at which the datapath loads a new word (slot start)
   localparam logic [3:0] SLOT_LOAD  = 4'd0;
   // last bit of a stereo frame; the next strobe starts the left channel
   localparam logic [4:0] FRAME_LAST = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREFETCH = 2'd1,
      ST_RUN      = 2'd2,
      ST_DRAIN    = 2'd3
   } state_t;

   // FIFO fetches are allowed while preparing or streaming. While draining,
   // only the right-channel word still to be sent may be fetched, so the
   // window closes once the frame enters its right half.
   function automatic logic fetch_allowed(input state_t st, input logic right_half);
      logic ok;
      ok = 1'b0;
      case (st)
         ST_PREFETCH: ok = 1'b1;
         ST_RUN:      ok = 1'b1;
         ST_DRAIN:    ok = ~right_half;
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/i2s_stage.sv
// ----------------------------------------------------------------------------
// i2s_stage
// One-word staging register between the sample FIFO and the I2S datapath.
// Issues single FIFO pops and captures the returned word one cycle later.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   fetch_en     controller allows a FIFO fetch this cycle
//   fifo_empty   FIFO has no word
//   fifo_rdata   FIFO read data, valid the cycle after fifo_rd
//   consume      datapath loaded a word this cycle (slot start while streaming)
//   fifo_rd      one-cycle FIFO pop pulse
//   stage_valid  staging register holds an unsent word
//   stage_data   staged word
// ----------------------------------------------------------------------------
module i2s_stage
   import i2s_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rdata,
   input  logic              consume,
   output logic              fifo_rd,
   output logic              stage_valid,
   output logic [DATA_W-1:0] stage_data
);

   logic rd_pend;   // a pop has been issued and its data not yet captured
   logic rd_q;      // fifo_rd delayed: fifo_rdata is valid this cycle
   logic issue;

   assign issue = fetch_en & ~stage_valid & ~rd_pend & ~fifo_empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: stage_data is a single register, not a memory array, so it
         // is reset cheaply; a reset also drops rd_q, which discards any
         // read that was in flight.
         fifo_rd     <= 1'b0;
         rd_q        <= 1'b0;
         rd_pend     <= 1'b0;
         stage_valid <= 1'b0;
         stage_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments let every register here sample the
         // pre-edge values of its neighbours, independent of statement order.
         fifo_rd <= issue;
         rd_q    <= fifo_rd;

         if (issue)
            rd_pend <= 1'b1;
         else if (rd_q)
            rd_pend <= 1'b0;

         // A capture only happens while stage_valid is clear, so a capture
         // landing on a load event leaves the slot as an underrun and keeps
         // the new word for the following slot.
         if (rd_q) begin
            stage_data  <= fifo_rdata;
            stage_valid <= 1'b1;
         end else if (consume) begin
            stage_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/i2s_ctrl.sv
// ----------------------------------------------------------------------------
// i2s_ctrl
// Control block for an I2S transmitter: sequences start/stop of streaming,
// feeds the datapath one word per slot from a staging register, and tracks
// underruns (slots where no word was ready).
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   enable        level request to stream audio
//   fifo_empty    sample FIFO has no word
//   fifo_rdata    FIFO read data, valid the cycle after fifo_rd
//   fifo_rd       one-cycle FIFO pop pulse
//   strobe        datapath bit strobe, one clk wide per bclk period
//   cnt_lrc       datapath slot/bit counter; bit 4 = channel (0 left, 1 right)
//   load_data     datapath load command
//   shift_data    datapath shift command
//   tx_data       word presented to the datapath
//   busy          controller not idle
//   underrun      sticky underrun flag
//   underrun_clr  clears underrun and underrun_cnt
//   underrun_cnt  saturating count of underrun slots
// ----------------------------------------------------------------------------
module i2s_ctrl
   import i2s_pkg::*;
#(
   parameter int UCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              fifo_rd,
   input  logic              strobe,
   input  logic [4:0]        cnt_lrc,
   output logic              load_data,
   output logic              shift_data,
   output logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              underrun,
   input  logic              underrun_clr,
   output logic [UCNT_W-1:0] underrun_cnt
);

   state_t            state;
   logic              streaming;
   logic              load_ev;
   logic              consume;
   logic              fetch_en;
   logic              underrun_ev;
   logic              stage_valid;
   logic [DATA_W-1:0] stage_data;

   // Load/shift follow the counter in every state; in IDLE tx_data is zero,
   // so the datapath simply shifts out silence.
   assign load_data  = (cnt_lrc[3:0] == SLOT_LOAD);
   assign shift_data = ~load_data;
   assign load_ev    = strobe & load_data;

   assign streaming   = (state == ST_RUN) || (state == ST_DRAIN);
   assign consume     = load_ev & streaming;
   assign underrun_ev = consume & ~stage_valid;
   assign fetch_en    = fetch_allowed(state, cnt_lrc[4]);

   assign tx_data = (streaming && stage_valid) ? stage_data : '0;
   assign busy    = (state != ST_IDLE);

   i2s_stage u_stage (
      .clk         (clk),
      .rst         (rst),
      .fetch_en    (fetch_en),
      .fifo_empty  (fifo_empty),
      .fifo_rdata  (fifo_rdata),
      .consume     (consume),
      .fifo_rd     (fifo_rd),
      .stage_valid (stage_valid),
      .stage_data  (stage_data)
   );

   // Streaming starts only on a frame boundary with a word already staged,
   // so the first word loaded is always a left-channel sample. A drain runs
   // to the end of the current frame so the right channel is never cut off.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable)
                  state <= ST_PREFETCH;
            end
            ST_PREFETCH: begin
               if (!enable)
                  state <= ST_IDLE;
               else if (strobe && (cnt_lrc == FRAME_LAST) && stage_valid)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               if (!enable)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (strobe && (cnt_lrc == FRAME_LAST))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A clear wins over an underrun in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else if (underrun_clr) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else if (underrun_ev) begin
         underrun <= 1'b1;
         if (underrun_cnt != '1)
            underrun_cnt <= underrun_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_i2s_ctrl.sv
// ----------------------------------------------------------------------------
// tb_i2s_ctrl
// Directed testbench for i2s_ctrl. The bench plays the datapath (strobe and
// cnt_lrc, one strobe every two clocks) and a simple sample FIFO; expected
// values are hand-computed for each step.
// ----------------------------------------------------------------------------
module tb_i2s_ctrl;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        fifo_empty;
   logic [15:0] fifo_rdata;
   logic        fifo_rd;
   logic        strobe;
   logic [4:0]  cnt_lrc;
   logic        load_data;
   logic        shift_data;
   logic [15:0] tx_data;
   logic        busy;
   logic        underrun;
   logic        underrun_clr;
   logic [7:0]  underrun_cnt;

   int checks   = 0;
   int failures = 0;

   i2s_ctrl #(.UCNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .fifo_empty   (fifo_empty),
      .fifo_rdata   (fifo_rdata),
      .fifo_rd      (fifo_rd),
      .strobe       (strobe),
      .cnt_lrc      (cnt_lrc),
      .load_data    (load_data),
      .shift_data   (shift_data),
      .tx_data      (tx_data),
      .busy         (busy),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .underrun_cnt (underrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sample FIFO: data appears on fifo_rdata the cycle after fifo_rd.
   logic [15:0] fifo_mem [0:15];
   int unsigned wr_ptr   = 0;
   int unsigned rd_ptr   = 0;
   int unsigned rd_count = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_rdata <= fifo_mem[rd_ptr[3:0]];
         rd_ptr     <= rd_ptr + 1;
         rd_count   <= rd_count + 1;
      end
   end

   task automatic push(input logic [15:0] w);
      fifo_mem[wr_ptr[3:0]] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One bclk period starting at a negedge: strobe for one clk, then idle.
   task automatic bclk(input logic [4:0] c);
      cnt_lrc = c;
      strobe  = 1'b1;
      @(negedge clk);
      strobe  = 1'b0;
      @(negedge clk);
   endtask

   task automatic bclks(input int lo, input int hi);
      for (int c = lo; c <= hi; c++) bclk(5'(c));
   endtask

   task automatic frame();
      bclks(0, 31);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b0;
      enable       = 1'b0;
      strobe       = 1'b0;
      cnt_lrc      = 5'd0;
      underrun_clr = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_fifo_rd",   fifo_rd,      1'b0);
      check("rst_busy",      busy,         1'b0);
      check("rst_underrun",  underrun,     1'b0);
      check("rst_ucnt",      underrun_cnt, 8'd0);
      check("rst_tx",        tx_data,      16'h0000);
      check("load_at_0",     load_data,    1'b1);
      check("shift_at_0",    shift_data,   1'b0);
      cnt_lrc = 5'd5;
      #1;
      check("load_at_5",     load_data,    1'b0);
      check("shift_at_5",    shift_data,   1'b1);
      rst = 1'b1;
      @(negedge clk);

      // IDLE ignores slots: no fetch, no underrun
      push(16'hA5A5);
      push(16'h5A5A);
      bclk(5'd0);
      bclk(5'd16);
      check("idle_no_rd",    rd_count,     32'd0);
      check("idle_no_ur",    underrun,     1'b0);
      check("idle_busy",     busy,         1'b0);

      // Start: first word goes out on the left channel
      enable = 1'b1;
      bclks(20, 31);
      check("run_busy",      busy,         1'b1);
      check("prefetch_rds",  rd_count,     32'd1);
      check("left_word",     tx_data,      16'hA5A5);
      bclks(0, 15);
      check("right_word",    tx_data,      16'h5A5A);
      bclk(5'd16);
      check("no_ur_flag",    underrun,     1'b0);
      check("no_ur_cnt",     underrun_cnt, 8'd0);
      check("two_rds",       rd_count,     32'd2);

      // FIFO runs dry: each empty slot counts
      bclks(17, 31);
      check("empty_tx",      tx_data,      16'h0000);
      bclk(5'd0);
      check("ur_flag",       underrun,     1'b1);
      check("ur_cnt_1",      underrun_cnt, 8'd1);
      bclks(1, 16);
      check("ur_cnt_2",      underrun_cnt, 8'd2);

      // Capture landing on a load edge: slot is an underrun, word kept
      bclks(17, 30);
      push(16'h1234);
      bclk(5'd31);
      check("coinc_tx0",     tx_data,      16'h0000);
      bclk(5'd0);
      check("coinc_ur_cnt",  underrun_cnt, 8'd3);
      check("coinc_ur_flag", underrun,     1'b1);
      check("coinc_kept",    tx_data,      16'h1234);
      bclks(1, 16);
      check("coinc_sent",    underrun_cnt, 8'd3);

      // Drain: enable drops at cnt 5, right word still fetched and loaded
      push(16'h1111);
      bclks(17, 31);
      check("drain_left",    tx_data,      16'h1111);
      bclks(0, 4);
      enable = 1'b0;
      bclk(5'd5);
      check("drain_busy",    busy,         1'b1);
      push(16'h2222);
      bclks(6, 15);
      check("drain_right",   tx_data,      16'h2222);
      bclk(5'd16);
      check("drain_no_ur",   underrun_cnt, 8'd3);
      check("drain_rds",     rd_count,     32'd5);
      push(16'h3333);
      bclks(17, 19);
      enable = 1'b1;
      bclks(20, 25);
      enable = 1'b0;
      bclks(26, 30);
      check("drain_hold",    busy,         1'b1);
      check("drain_no_rd",   rd_count,     32'd5);
      bclk(5'd31);
      check("drain_idle",    busy,         1'b0);
      check("idle_tx",       tx_data,      16'h0000);
      check("idle_no_rd2",   rd_count,     32'd5);

      // Clear, then saturate the counter
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      check("clr_cnt",       underrun_cnt, 8'd0);
      check("clr_flag",      underrun,     1'b0);
      enable = 1'b1;
      repeat (6) @(negedge clk);
      check("restart_rd",    rd_count,     32'd6);
      bclk(5'd31);
      frame();
      check("sat_cnt_1",     underrun_cnt, 8'd1);
      repeat (127) frame();
      check("sat_cnt_255",   underrun_cnt, 8'd255);
      frame();
      check("sat_hold",      underrun_cnt, 8'd255);
      check("sat_flag",      underrun,     1'b1);

      // Clear coincident with an underrun slot
      cnt_lrc      = 5'd0;
      strobe       = 1'b1;
      underrun_clr = 1'b1;
      @(negedge clk);
      check("clr_prio_cnt",  underrun_cnt, 8'd0);
      check("clr_prio_flag", underrun,     1'b0);
      strobe       = 1'b0;
      underrun_clr = 1'b0;
      @(negedge clk);

      // Reset while a read is in flight
      push(16'hBEEF);
      @(negedge clk);
      check("inflight_rd",   fifo_rd,      1'b1);
      rst    = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      check("mid_rst_rd",    fifo_rd,      1'b0);
      check("mid_rst_busy",  busy,         1'b0);
      check("mid_rst_ur",    underrun,     1'b0);
      check("mid_rst_cnt",   underrun_cnt, 8'd0);
      check("mid_rst_tx",    tx_data,      16'h0000);
      check("mid_rst_sv",    dut.stage_valid, 1'b0);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_sv",   dut.stage_valid, 1'b0);
      check("post_rst_rd",   fifo_rd,      1'b0);
      check("post_rst_busy", busy,         1'b0);
      check("post_rst_rds",  rd_count,     32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
